jts16b_sndlatch: RTL and testbench

JTS16B_SNDLATCH -- requirements
Module: jts16b_sndlatch

---
 rtl/jts16b_pkg.sv | 14 +
 rtl/jts16b_sndlatch_fifo.sv | 72 +++++++
 rtl/jts16b_sndlatch.sv | 95 +++++++++
 tb/tb_jts16b_sndlatch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jts16b_pkg.sv
// Shared constants and helpers for the System 16B sound latch.
// Depth legality, status bit positions and pointer sizing.
package jts16b_pkg;
  localparam int ST_FULL = 0;
  localparam int ST_RPLY = 1;

  function automatic bit depth_ok(int d);
    return d == 1 || d == 2 || d == 4 || d == 8;
  endfunction

  function automatic int ptr_w(int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/jts16b_sndlatch_fifo.sv
// Command FIFO between main CPU and sound CPU.
// Storage, wrap-around pointers and occupancy count.
module jts16b_sndlatch_fifo
  import jts16b_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       pend,
  output logic       full,
  output logic       drop
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    last;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pend    = count != '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop & pend & ~clr;
  assign do_push = push & ~clr & (~full | do_pop);
  assign drop    = push & ~clr & full & ~do_pop;

  // Once drained, keep showing the last byte stored.
  assign dout = pend ? mem[rd_ptr] : last;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= 8'h00;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= nxt(wr_ptr);
        last   <= din;
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/jts16b_sndlatch.sv
// Main/sound CPU mailbox: command FIFO plus reply latch.
// Strobes are edge-detected against registered copies.
module jts16b_sndlatch
  import jts16b_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       main_rd,
  output logic [7:0] main_dout,
  output logic [1:0] main_st,
  input  logic       snd_rd,
  input  logic       snd_wr,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_pbf,
  input  logic       snd_clr,
  output logic       ovf
);
  localparam int D = depth_ok(DEPTH) ? DEPTH : 1;

  logic arm;
  logic wr_q;
  logic rd_q;
  logic swr_q;
  logic mrd_q;
  logic push;
  logic pop;
  logic rply_set;
  logic rply_clr;
  logic rply_pend;
  logic full;
  logic drop;

  // arm masks the first cycle after reset so held levels are not edges
  assign push     = arm & main_wr & ~wr_q;
  assign pop      = arm & ~snd_rd & rd_q;
  assign rply_set = arm & snd_wr & ~swr_q;
  assign rply_clr = arm & ~main_rd & mrd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm   <= 1'b0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      swr_q <= 1'b0;
      mrd_q <= 1'b0;
    end else begin
      arm   <= 1'b1;
      wr_q  <= main_wr;
      rd_q  <= snd_rd;
      swr_q <= snd_wr;
      mrd_q <= main_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_dout <= 8'h00;
      rply_pend <= 1'b0;
    end else if (rply_set) begin
      main_dout <= snd_din;
      rply_pend <= 1'b1;
    end else if (rply_clr) begin
      rply_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (snd_clr) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

  jts16b_sndlatch_fifo #(
    .DEPTH(D)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (snd_clr),
    .push (push),
    .pop  (pop),
    .din  (main_din),
    .dout (snd_dout),
    .pend (snd_pbf),
    .full (full),
    .drop (drop)
  );

  assign main_st[ST_FULL] = full;
  assign main_st[ST_RPLY] = rply_pend;
endmodule

// File: tb/tb_jts16b_sndlatch.sv
// Directed bench for jts16b_sndlatch at DEPTH 1, 2 and 4.
// Shared stimulus; each step checks the instance it targets.
module tb_jts16b_sndlatch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       main_wr = 1'b0;
  logic [7:0] main_din = 8'h00;
  logic       main_rd = 1'b0;
  logic       snd_rd = 1'b0;
  logic       snd_wr = 1'b0;
  logic [7:0] snd_din = 8'h00;
  logic       snd_clr = 1'b0;

  logic [7:0] mdo1, mdo2, mdo4;
  logic [1:0] st1, st2, st4;
  logic [7:0] sdo1, sdo2, sdo4;
  logic       pbf1, pbf2, pbf4;
  logic       ovf1, ovf2, ovf4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jts16b_sndlatch #(.DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .main_wr(main_wr), .main_din(main_din),
    .main_rd(main_rd), .main_dout(mdo1),
    .main_st(st1), .snd_rd(snd_rd),
    .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_dout(sdo1), .snd_pbf(pbf1),
    .snd_clr(snd_clr), .ovf(ovf1)
  );

  jts16b_sndlatch #(.DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .main_wr(main_wr), .main_din(main_din),
    .main_rd(main_rd), .main_dout(mdo2),
    .main_st(st2), .snd_rd(snd_rd),
    .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_dout(sdo2), .snd_pbf(pbf2),
    .snd_clr(snd_clr), .ovf(ovf2)
  );

  jts16b_sndlatch #(.DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .main_wr(main_wr), .main_din(main_din),
    .main_rd(main_rd), .main_dout(mdo4),
    .main_st(st4), .snd_rd(snd_rd),
    .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_dout(sdo4), .snd_pbf(pbf4),
    .snd_clr(snd_clr), .ovf(ovf4)
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_b(input logic [7:0] d);
    main_din = d;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    tick();
  endtask

  task automatic pop_b();
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
    tick();
  endtask

  task automatic clr_p();
    snd_clr = 1'b1;
    tick();
    snd_clr = 1'b0;
    tick();
  endtask

  initial begin
    tick(2);
    chk("rst_sdo", sdo1, 8'h00);
    chk("rst_mdo", mdo1, 8'h00);
    chk("rst_st", {6'd0, st1}, 8'h00);
    chk("rst_pbf", {7'd0, pbf1}, 8'h00);
    chk("rst_ovf", {7'd0, ovf1}, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // single latch, held write
    main_din = 8'hA5;
    main_wr  = 1'b1;
    tick();
    chk("d1_pbf", {7'd0, pbf1}, 8'h01);
    chk("d1_sdo", sdo1, 8'hA5);
    chk("d1_full", {6'd0, st1}, 8'h01);
    tick(3);
    main_wr = 1'b0;
    tick();
    chk("d1_held_ovf", {7'd0, ovf1}, 8'h00);
    chk("d1_held_pbf", {7'd0, pbf1}, 8'h01);
    snd_rd = 1'b1;
    tick();
    chk("d1_rd_hi_pbf", {7'd0, pbf1}, 8'h01);
    snd_rd = 1'b0;
    tick();
    chk("d1_pop_pbf", {7'd0, pbf1}, 8'h00);
    chk("d1_pop_st", {6'd0, st1}, 8'h00);
    clr_p();

    // depth 4 overflow
    push_b(8'h01);
    push_b(8'h02);
    push_b(8'h03);
    chk("d4_3_full", {6'd0, st4}, 8'h00);
    push_b(8'h04);
    chk("d4_4_full", {6'd0, st4}, 8'h01);
    chk("d4_4_ovf", {7'd0, ovf4}, 8'h00);
    push_b(8'h05);
    chk("d4_5_ovf", {7'd0, ovf4}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      chk("d4_rd", sdo4, 8'(i));
      pop_b();
    end
    chk("d4_empty_pbf", {7'd0, pbf4}, 8'h00);
    chk("d4_empty_sdo", sdo4, 8'h04);
    chk("d4_ovf_sticky", {7'd0, ovf4}, 8'h01);
    clr_p();
    chk("clr_ovf", {7'd0, ovf4}, 8'h00);

    // depth 2 full, push and pop together
    push_b(8'h11);
    push_b(8'h22);
    chk("d2_full", {6'd0, st2}, 8'h01);
    snd_rd = 1'b1;
    tick();
    main_din = 8'h33;
    main_wr  = 1'b1;
    snd_rd   = 1'b0;
    tick();
    main_wr = 1'b0;
    chk("d2_pp_full", {6'd0, st2}, 8'h01);
    chk("d2_pp_ovf", {7'd0, ovf2}, 8'h00);
    chk("d2_pp_head", sdo2, 8'h22);
    tick();
    pop_b();
    chk("d2_tail", sdo2, 8'h33);
    chk("d2_tail_pbf", {7'd0, pbf2}, 8'h01);
    pop_b();
    chk("d2_drain", {7'd0, pbf2}, 8'h00);

    // pop on empty
    chk("e_sdo0", sdo4, 8'h33);
    pop_b();
    chk("e_sdo1", sdo4, 8'h33);
    chk("e_pbf", {7'd0, pbf4}, 8'h00);
    push_b(8'h44);
    chk("e_next", sdo4, 8'h44);
    chk("e_next_pbf", {7'd0, pbf4}, 8'h01);
    pop_b();
    chk("e_next_pop", {7'd0, pbf4}, 8'h00);

    // reply path
    snd_din = 8'h7E;
    snd_wr  = 1'b1;
    tick();
    chk("rp_set", {6'd0, st1}, 8'h02);
    chk("rp_dout", mdo1, 8'h7E);
    snd_wr = 1'b0;
    tick();
    main_rd = 1'b1;
    tick();
    chk("rp_rd_hi", {6'd0, st1}, 8'h02);
    main_rd = 1'b0;
    tick();
    chk("rp_clr", {6'd0, st1}, 8'h00);
    chk("rp_hold", mdo1, 8'h7E);

    // flush then reset mid-strobe
    clr_p();
    push_b(8'h61);
    push_b(8'h62);
    push_b(8'h63);
    chk("q3_pbf", {7'd0, pbf4}, 8'h01);
    chk("q3_sdo", sdo4, 8'h61);
    chk("q3_ovf1", {7'd0, ovf1}, 8'h01);
    snd_din = 8'h5A;
    snd_wr  = 1'b1;
    tick();
    snd_wr = 1'b0;
    tick();
    clr_p();
    chk("fl_pbf", {7'd0, pbf4}, 8'h00);
    chk("fl_st", {6'd0, st4}, 8'h02);
    chk("fl_ovf", {7'd0, ovf1}, 8'h00);
    chk("fl_rply", mdo4, 8'h5A);
    push_b(8'h71);
    main_din = 8'h72;
    main_wr  = 1'b1;
    snd_wr   = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_sdo", sdo4, 8'h00);
    chk("rs_mdo", mdo4, 8'h00);
    chk("rs_st", {6'd0, st4}, 8'h00);
    chk("rs_pbf", {7'd0, pbf4}, 8'h00);
    chk("rs_ovf", {7'd0, ovf4}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rl_pbf", {7'd0, pbf4}, 8'h00);
    chk("rl_st", {6'd0, st4}, 8'h00);
    chk("rl_mdo", mdo4, 8'h00);
    main_wr = 1'b0;
    snd_wr  = 1'b0;
    tick();
    push_b(8'h81);
    chk("rl_push", sdo4, 8'h81);
    chk("rl_push_pbf", {7'd0, pbf4}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
